// File: rtl/alu_muldiv.sv
// Single-cycle ALU with an iterative multiply/divide unit.
// Mul/div run on magnitudes; signs are restored in one extra fix-up cycle.
module alu_muldiv #(
    parameter int WIDTH     = 32,
    parameter int ITER_BITS = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    input  logic             start,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    localparam logic [ITER_BITS-1:0] LAST = ITER_BITS'(WIDTH - 1);

    state_t               state;
    logic [ITER_BITS-1:0] count;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     mq;
    logic [WIDTH-1:0]     opb;
    logic [WIDTH-1:0]     a_hold;
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;
    logic                 b_zero;

    logic [WIDTH-1:0] sum_add;
    logic [WIDTH-1:0] diff_sub;
    logic             ovf_add;
    logic             ovf_sub;
    logic             slt;
    logic             sltu;

    logic             is_md;
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Combinational ALU path
    assign sum_add  = a + b;
    assign diff_sub = a - b;
    assign ovf_add  = (a[WIDTH-1] == b[WIDTH-1]) &&
                      (sum_add[WIDTH-1] != a[WIDTH-1]);
    assign ovf_sub  = (a[WIDTH-1] != b[WIDTH-1]) &&
                      (diff_sub[WIDTH-1] != a[WIDTH-1]);
    assign slt      = $signed(a) < $signed(b);
    assign sltu     = a < b;

    always_comb begin
        out      = '0;
        overflow = 1'b0;
        case (sel)
            4'b0000: out = a & b;
            4'b0001: out = a | b;
            4'b0010: begin
                out      = sum_add;
                overflow = ovf_add;
            end
            4'b0011: out = a ^ b;
            4'b0100: out = ~(a | b);
            4'b0101: out = {{(WIDTH-1){1'b0}}, slt};
            4'b0110: begin
                out      = diff_sub;
                overflow = ovf_sub;
            end
            4'b0111: out = {{(WIDTH-1){1'b0}}, sltu};
            4'b1000,
            4'b1001,
            4'b1010,
            4'b1011: out = lo;
            4'b1100: out = hi;
            4'b1101: out = lo;
            default: out = '0;
        endcase
    end

    assign zero = (out == '0);

    // Operand capture: magnitudes plus the signs needed at fix-up
    assign is_md = sel[3] & ~sel[2];
    assign sgn   = sel[0];
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // One iteration step for each algorithm
    assign mul_sum   = {1'b0, acc} + {1'b0, (mq[0] ? opb : '0)};
    assign div_shift = {acc, mq[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_ge    = div_shift >= {1'b0, opb};

    assign prod     = {acc, mq};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = neg_q ? -mq : mq;
    assign rem_fix  = neg_r ? -acc : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            mq     <= '0;
            opb    <= '0;
            a_hold <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_md) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        count  <= '0;
                        acc    <= '0;
                        mq     <= a_mag;
                        opb    <= b_mag;
                        a_hold <= a;
                        is_div <= sel[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        b_zero <= (b == '0);
                    end
                end
                RUN: begin
                    if (is_div) begin
                        acc <= div_ge ? div_diff[WIDTH-1:0]
                                      : div_shift[WIDTH-1:0];
                        mq  <= {mq[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        mq  <= {mul_sum[0], mq[WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (b_zero) begin
                        hi <= a_hold;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 Parameter ITER_BITS, default $clog2(WIDTH+1), iteration-counter width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a  input  WIDTH  operand A (dividend/multiplicand for mul/div).
REQ-006 b  input  WIDTH  operand B (divisor/multiplier for mul/div).
REQ-007 sel  input  4  operation select, encoding per REQ-012.
REQ-008 start  input  1  launches a mul/div operation when sel is a mul/div code.
REQ-009 out  output  WIDTH  combinational result.
REQ-010 zero  output  1  high when out == 0.
REQ-011 overflow  output  1  signed overflow flag for ADD/SUB, 0 for all other ops; busy/done/hi/lo are output WIDTH/1 as per REQ-013..REQ-016.

Function
REQ-012 Encodings: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLT (signed), 0110 SUB, 0111 SLTU (unsigned), 1000 MULTU, 1001 MULT, 1010 DIVU, 1011 DIV, 1100 MFHI, 1101 MFLO; 1110/1111 give out = 0.
REQ-013 busy  output  1  high while the iterative unit is running.
REQ-014 done  output  1  one-cycle pulse when hi/lo have been loaded.
REQ-015 hi  output  WIDTH  product high half / division remainder (registered).
REQ-016 lo  output  WIDTH  product low half / division quotient (registered).
REQ-017 Logic/arith ops: out valid combinationally in the same cycle; ADD/SUB wrap modulo 2^WIDTH.
REQ-018 SLT/SLTU: out = 1 (zero-extended) if a < b under signed/unsigned compare, else 0.
REQ-019 overflow for ADD: operand signs equal and result sign differs; SUB: operand signs differ and result sign differs from a.
REQ-020 MFHI/MFLO: out = hi/lo; for mul/div codes out = lo.
REQ-021 FSM states IDLE, RUN, FIX, DONE; reset to IDLE.
REQ-022 IDLE -> RUN on edge E0 where start=1 and sel in 1000..1011; a, b, signedness and op latched at E0; start with other sel codes ignored.
REQ-023 RUN: one shift-add (mul) or restoring shift-subtract (div) step per edge, E1..E_WIDTH, on magnitudes; RUN -> FIX at E_WIDTH.
REQ-024 FIX: sign correction applied, hi/lo loaded at E_WIDTH+1, FIX -> DONE.
REQ-025 DONE: done=1 for exactly one cycle, then -> IDLE; start in DONE is ignored.
REQ-026 busy = 1 in RUN and FIX (from E0 to E_WIDTH+1); busy = 0 in IDLE and DONE.
REQ-027 start while busy or in DONE is ignored; latched operands unaffected by a/b changes after E0.
REQ-028 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit signed/unsigned product.
REQ-029 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-030 Divide by zero (both): lo = all ones, hi = a; no other flag.
REQ-031 DIV of most-negative value by -1: lo = most-negative value, hi = 0.
REQ-032 hi/lo hold their values between operations; only the FIX-state load changes them.

Reset
REQ-033 rst_n low asynchronously forces IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators=0.
REQ-034 Reset mid-operation aborts; no done pulse; hi/lo read 0 after release.
REQ-035 First start is accepted on the first rising edge with rst_n high.

Verification (WIDTH=32)
REQ-036 ADD a=0x7FFFFFFF b=1 -> out=0x80000000, overflow=1, zero=0; SUB a=5 b=5 -> out=0, zero=1, overflow=0.
REQ-037 SLT a=0xFFFFFFFF b=1 -> out=1; SLTU same operands -> out=0.
REQ-038 MULT a=-3 b=5 start at E0 -> done at E33 only, busy E0..E33, hi=0xFFFFFFFF lo=0xFFFFFFF1; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
REQ-039 DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=10 b=0 -> lo=0xFFFFFFFF, hi=0x0000000A; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-040 start pulsed again during RUN with new operands -> ignored, first result intact; rst_n low at E10 of a MULT -> busy=0, no done, hi=lo=0.
